reg_sequencer: RTL and testbench

Command sequencer that drives the accumulator register's control strobes and the ALU operand and opcode inputs from a stream of instruction words. It accepts one instruction per valid/ready handshake and expands it into one or more single-cycle register strobes. After the last register update it returns the register value on a valid/ready response channel. It sits between instruction fetch/decode and the register/ALU datapath, and is the hardware master for the strobe interface that the datapath blocks expect.

---
 rtl/reg_sequencer.sv | 155 +++++++++++++++
 tb/tb_reg_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_sequencer.sv
// Instruction sequencer: expands one command word into single-cycle register/ALU strobes
// and returns the resulting register value on a valid/ready response channel.
module reg_sequencer #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W+3:0] req_instr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              reg_cl,
    output logic              reg_ld,
    output logic              reg_inc,
    output logic              reg_dec,
    output logic              reg_sr,
    output logic              reg_ir,
    output logic              reg_sl,
    output logic              reg_il,
    output logic [DATA_W-1:0] reg_in,
    input  logic [DATA_W-1:0] reg_q,
    output logic [2:0]        alu_oc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_f
);

    localparam int CNT_W = DATA_W + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] load_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              alu_exec;
    logic              rsp_fresh;
    logic [3:0]        cmd;
    logic [DATA_W-1:0] imm;
    logic [CNT_W-1:0]  n_req;

    assign cmd = req_instr[DATA_W+3:DATA_W];
    assign imm = req_instr[DATA_W-1:0];

    function automatic logic [CNT_W-1:0] strobe_count(input logic [3:0] c,
                                                      input logic [DATA_W-1:0] i);
        logic [CNT_W-1:0] n;
        n = '0;
        case (c)
            4'd1, 4'd2: n = CNT_W'(1);
            4'd3, 4'd4: n = (i == '0) ? (CNT_W'(1) << DATA_W) : CNT_W'(i);
            4'd5, 4'd6: n = (i[DATA_W-2:0] == '0) ? (CNT_W'(1) << (DATA_W-1))
                                                  : CNT_W'(i[DATA_W-2:0]);
            default:    n = c[3] ? CNT_W'(1) : '0;
        endcase
        return n;
    endfunction

    assign n_req     = strobe_count(cmd, imm);
    assign req_ready = (state == IDLE) && !rst;
    assign alu_a     = reg_q;
    // ALU result must be loaded in the same cycle the operands are presented
    assign reg_in    = alu_exec ? alu_f : load_q;
    // First RESP cycle sees the register right after its final update
    assign rsp_data  = rsp_fresh ? reg_q : rsp_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            reg_cl     <= 1'b0;
            reg_ld     <= 1'b0;
            reg_inc    <= 1'b0;
            reg_dec    <= 1'b0;
            reg_sr     <= 1'b0;
            reg_ir     <= 1'b0;
            reg_sl     <= 1'b0;
            reg_il     <= 1'b0;
            load_q     <= '0;
            alu_exec   <= 1'b0;
            alu_oc     <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_fresh  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cnt      <= n_req;
                        reg_cl   <= (cmd == 4'd1);
                        reg_ld   <= (cmd == 4'd2) || cmd[3];
                        reg_inc  <= (cmd == 4'd3);
                        reg_dec  <= (cmd == 4'd4);
                        reg_sr   <= (cmd == 4'd5);
                        reg_ir   <= (cmd == 4'd5) && imm[DATA_W-1];
                        reg_sl   <= (cmd == 4'd6);
                        reg_il   <= (cmd == 4'd6) && imm[DATA_W-1];
                        load_q   <= (cmd == 4'd2) ? imm : '0;
                        alu_exec <= cmd[3];
                        alu_oc   <= cmd[3] ? cmd[2:0] : 3'd0;
                        alu_b    <= cmd[3] ? imm : '0;
                        if (n_req == '0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_fresh <= 1'b1;
                            rsp_err   <= (cmd == 4'd7);
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == CNT_W'(1)) begin
                        state     <= RESP;
                        cnt       <= '0;
                        reg_cl    <= 1'b0;
                        reg_ld    <= 1'b0;
                        reg_inc   <= 1'b0;
                        reg_dec   <= 1'b0;
                        reg_sr    <= 1'b0;
                        reg_ir    <= 1'b0;
                        reg_sl    <= 1'b0;
                        reg_il    <= 1'b0;
                        load_q    <= '0;
                        alu_exec  <= 1'b0;
                        alu_oc    <= '0;
                        alu_b     <= '0;
                        rsp_valid <= 1'b1;
                        rsp_fresh <= 1'b1;
                        rsp_err   <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_fresh) begin
                        rsp_data_q <= reg_q;
                        rsp_fresh  <= 1'b0;
                    end
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench for reg_sequencer with a behavioural accumulator register and ALU.
module tb_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_instr;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
    logic [3:0] reg_in;
    logic [3:0] reg_q;
    logic [2:0] alu_oc;
    logic [3:0] alu_a, alu_b, alu_f;

    logic [3:0] mq = 4'd0;

    int checks   = 0;
    int failures = 0;

    int r_cyc, r_to, r_multi, r_rsp_strobe;
    int c_cl, c_ld, c_inc, c_dec, c_sr, c_sl, c_ir, c_il;
    logic [3:0] r_data;
    logic       r_err;

    always #5 clk = ~clk;

    reg_sequencer #(.DATA_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
        .reg_sr(reg_sr), .reg_ir(reg_ir), .reg_sl(reg_sl), .reg_il(reg_il),
        .reg_in(reg_in), .reg_q(reg_q),
        .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f)
    );

    // Accumulator register: not tied to the sequencer reset
    always @(posedge clk) begin
        if (reg_cl)       mq <= 4'd0;
        else if (reg_ld)  mq <= reg_in;
        else if (reg_inc) mq <= mq + 4'd1;
        else if (reg_dec) mq <= mq - 4'd1;
        else if (reg_sr)  mq <= {reg_ir, mq[3:1]};
        else if (reg_sl)  mq <= {mq[2:0], reg_il};
    end
    assign reg_q = mq;

    always_comb begin
        alu_f = 4'd0;
        case (alu_oc)
            3'd0: alu_f = alu_a + alu_b;
            3'd1: alu_f = alu_a - alu_b;
            3'd2: alu_f = alu_a & alu_b;
            3'd3: alu_f = alu_a | alu_b;
            3'd4: alu_f = alu_a ^ alu_b;
            3'd5: alu_f = ~alu_a;
            3'd6: alu_f = alu_b;
            default: alu_f = alu_a;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int strobe_sum();
        return int'(reg_cl) + int'(reg_ld) + int'(reg_inc) + int'(reg_dec)
             + int'(reg_sr) + int'(reg_sl);
    endfunction

    // Issue one instruction with rsp_ready=1 and record what the strobes did until the response
    task automatic run(input logic [7:0] instr);
        int ns;
        bit done;
        r_cyc = 0; r_to = 0; r_multi = 0; r_rsp_strobe = 0;
        c_cl = 0; c_ld = 0; c_inc = 0; c_dec = 0; c_sr = 0; c_sl = 0; c_ir = 0; c_il = 0;
        r_data = 4'd0; r_err = 1'b0;
        done = 1'b0;
        req_instr = instr;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            ns = strobe_sum();
            if (rsp_valid) begin
                r_cyc  = cyc;
                r_data = rsp_data;
                r_err  = rsp_err;
                if (ns != 0 || reg_ir || reg_il) r_rsp_strobe++;
                done = 1'b1;
            end else begin
                c_cl  += int'(reg_cl);
                c_ld  += int'(reg_ld);
                c_inc += int'(reg_inc);
                c_dec += int'(reg_dec);
                c_sr  += int'(reg_sr);
                c_sl  += int'(reg_sl);
                c_ir  += int'(reg_ir);
                c_il  += int'(reg_il);
                if (ns > 1) r_multi++;
            end
            tick();
        end
        if (!done) r_to = 1;
    endtask

    initial begin
        int bad_multi, bad_out, bad_data, bad_to;
        rst = 1'b1;
        req_valid = 1'b0;
        req_instr = 8'h00;
        rsp_ready = 1'b1;
        tick();
        tick();

        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_strobes", 32'(strobe_sum()), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_reg_in", 32'(reg_in), 32'd0);
        check("rst_alu_oc", 32'(alu_oc), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);

        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // LOAD 9, stepped by hand
        req_instr = 8'h29;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("load_c1_ld", 32'(reg_ld), 32'd1);
        check("load_c1_in", 32'(reg_in), 32'd9);
        check("load_c1_valid", 32'(rsp_valid), 32'd0);
        check("load_c1_ready", 32'(req_ready), 32'd0);
        tick();
        check("load_c2_ld", 32'(reg_ld), 32'd0);
        check("load_c2_valid", 32'(rsp_valid), 32'd1);
        check("load_c2_data", 32'(rsp_data), 32'd9);
        check("load_c2_err", 32'(rsp_err), 32'd0);
        tick();
        check("load_c3_valid", 32'(rsp_valid), 32'd0);
        check("load_c3_ready", 32'(req_ready), 32'd1);

        // INC by 3 from 14 wraps to 1
        run(8'h2E);
        check("ld14_data", 32'(r_data), 32'd14);
        run(8'h33);
        check("inc_count", 32'(c_inc), 32'd3);
        check("inc_rsp_cycle", 32'(r_cyc), 32'd4);
        check("inc_data", 32'(r_data), 32'd1);
        check("inc_timeout", 32'(r_to), 32'd0);

        // SHR by 2 with ir=1 from 0110
        run(8'h26);
        run(8'h5A);
        check("shr_count", 32'(c_sr), 32'd2);
        check("shr_ir_count", 32'(c_ir), 32'd2);
        check("shr_rsp_cycle", 32'(r_cyc), 32'd3);
        check("shr_data", 32'(r_data), 32'hD);

        // SHL count 0 means 8 shifts
        run(8'h60);
        check("shl_count", 32'(c_sl), 32'd8);
        check("shl_il_count", 32'(c_il), 32'd0);
        check("shl_rsp_cycle", 32'(r_cyc), 32'd9);
        check("shl_data", 32'(r_data), 32'd0);

        // DEC count 0 means 16 decrements: 0 -> 0
        run(8'h40);
        check("dec16_count", 32'(c_dec), 32'd16);
        check("dec16_rsp_cycle", 32'(r_cyc), 32'd17);
        check("dec16_data", 32'(r_data), 32'd0);

        // ALU AND: 5 & 3 = 1
        run(8'h25);
        req_instr = 8'hA3;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("alu_c1_oc", 32'(alu_oc), 32'd2);
        check("alu_c1_a", 32'(alu_a), 32'd5);
        check("alu_c1_b", 32'(alu_b), 32'd3);
        check("alu_c1_ld", 32'(reg_ld), 32'd1);
        check("alu_c1_in", 32'(reg_in), 32'd1);
        tick();
        check("alu_c2_valid", 32'(rsp_valid), 32'd1);
        check("alu_c2_data", 32'(rsp_data), 32'd1);
        check("alu_c2_oc", 32'(alu_oc), 32'd0);
        check("alu_c2_b", 32'(alu_b), 32'd0);
        tick();

        // Reserved command, then err clears on the next response
        run(8'h7F);
        check("rsvd_rsp_cycle", 32'(r_cyc), 32'd1);
        check("rsvd_err", 32'(r_err), 32'd1);
        check("rsvd_strobes", 32'(c_cl + c_ld + c_inc + c_dec + c_sr + c_sl), 32'd0);
        check("rsvd_data", 32'(r_data), 32'd1);
        run(8'h00);
        check("nop_rsp_cycle", 32'(r_cyc), 32'd1);
        check("nop_err", 32'(r_err), 32'd0);

        // Backpressure: LOAD 7 with rsp_ready low while random requests arrive
        rsp_ready = 1'b0;
        req_instr = 8'h27;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("bp_valid", 32'(rsp_valid), 32'd1);
        check("bp_data", 32'(rsp_data), 32'd7);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_instr = 8'($urandom);
            tick();
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_data", 32'(rsp_data), 32'd7);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        check("bp_reg_untouched", 32'(mq), 32'd7);

        // Random instruction stream
        bad_multi = 0; bad_out = 0; bad_data = 0; bad_to = 0;
        for (int i = 0; i < 1000; i++) begin
            run(8'($urandom));
            bad_multi += r_multi;
            bad_out   += r_rsp_strobe;
            bad_to    += r_to;
            if (r_data !== mq) bad_data++;
        end
        check("rand_onehot", 32'(bad_multi), 32'd0);
        check("rand_strobe_in_resp", 32'(bad_out), 32'd0);
        check("rand_rsp_data", 32'(bad_data), 32'd0);
        check("rand_timeout", 32'(bad_to), 32'd0);

        // Reset in cycle 2 of DEC 5 from 10
        run(8'h2A);
        req_instr = 8'h45;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("rstx_c1_dec", 32'(reg_dec), 32'd1);
        tick();
        check("rstx_c2_dec", 32'(reg_dec), 32'd1);
        rst = 1'b1;
        #1;
        check("rstx_dec_dropped", 32'(reg_dec), 32'd0);
        check("rstx_strobes", 32'(strobe_sum()), 32'd0);
        check("rstx_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstx_req_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rstx_ready_after", 32'(req_ready), 32'd1);
        check("rstx_reg_kept", 32'(mq), 32'd9);
        run(8'h00);
        check("rstx_nop_cycle", 32'(r_cyc), 32'd1);
        check("rstx_nop_data", 32'(r_data), 32'd9);
        check("rstx_nop_err", 32'(r_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
